// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-to-host buffer signals between the UART receiver, the FIFO and the host
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_done_tick;
    logic                  rd;
    logic                  clr_overrun;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  empty;
    logic                  full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overrun;

    modport master (
        output rx_data, rx_done_tick, rd, clr_overrun,
        input  r_data, empty, full, count, overrun
    );

    modport slave (
        input  rx_data, rx_done_tick, rd, clr_overrun,
        output r_data, empty, full, count, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through FIFO capturing UART words on the rising edge of rx_done_tick
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input logic           clk,
    input logic           reset,
    uart_rx_fifo_if.slave bus
);
    localparam logic [ADDR_WIDTH:0]   DEPTH   = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  tick_q, overrun;
    logic                  empty, full, wr_pulse, do_rd, do_wr, drop;

    assign empty    = count == '0;
    assign full     = count == DEPTH;
    assign wr_pulse = bus.rx_done_tick & ~tick_q;
    assign do_rd    = bus.rd & ~empty;
    // a read on a full FIFO frees the slot the simultaneous write lands in
    assign do_wr    = wr_pulse & (~full | do_rd);
    assign drop     = wr_pulse & full & ~do_rd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tick_q  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            tick_q  <= bus.rx_done_tick;
            wr_ptr  <= do_wr ? wr_ptr + PTR_ONE : wr_ptr;
            rd_ptr  <= do_rd ? rd_ptr + PTR_ONE : rd_ptr;
            count   <= (do_wr && !do_rd) ? count + CNT_ONE :
                       (do_rd && !do_wr) ? count - CNT_ONE : count;
            overrun <= drop | (overrun & ~bus.clr_overrun);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= bus.rx_data;
    end

    assign bus.r_data  = empty ? '0 : mem[rd_ptr];
    assign bus.empty   = empty;
    assign bus.full    = full;
    assign bus.count   = count;
    assign bus.overrun = overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: vector table, directed corner sequences and random traffic against a queue model
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();
    uart_rx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int errors = 0;

    logic [7:0] q [$];
    logic       m_ovr = 1'b0;
    logic       m_prev = 1'b0;

    typedef struct {
        logic       tick;
        logic [7:0] data;
        logic       rd;
        logic       clr;
        int         e_count;
        logic       e_empty;
        logic       e_full;
        logic [7:0] e_rdata;
        logic       e_ovr;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("count", 32'(bus.count), 32'(q.size()));
        check("empty", 32'(bus.empty), 32'(q.size() == 0));
        check("full", 32'(bus.full), 32'(q.size() == DEPTH));
        check("r_data", 32'(bus.r_data), q.size() != 0 ? 32'(q[0]) : 32'd0);
        check("overrun", 32'(bus.overrun), 32'(m_ovr));
    endtask

    task automatic model_reset();
        q.delete();
        m_ovr = 1'b0;
        m_prev = 1'b0;
    endtask

    task automatic step(input logic t, input logic [7:0] d, input logic r, input logic c);
        logic pulse, pop, drop;
        bus.rx_done_tick = t;
        bus.rx_data = d;
        bus.rd = r;
        bus.clr_overrun = c;
        @(posedge clk);
        pulse = t && !m_prev;
        m_prev = t;
        pop = r && q.size() != 0;
        drop = pulse && q.size() == DEPTH && !pop;
        if (pop) void'(q.pop_front());
        if (pulse && !drop) q.push_back(d);
        m_ovr = drop || (m_ovr && !c);
        #1 compare_model();
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0);
        step(1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        bus.rx_done_tick = 1'b0;
        bus.rx_data = '0;
        bus.rd = 1'b0;
        bus.clr_overrun = 1'b0;
        repeat (3) @(posedge clk);
        #1 compare_model();
        @(negedge clk) reset = 1'b1;

        // plan 1, 2 and the empty-FIFO coincidences
        vecs.push_back('{1, 8'hA5, 0, 0, 1, 0, 0, 8'hA5, 0});
        vecs.push_back('{0, 8'h00, 0, 0, 1, 0, 0, 8'hA5, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0});
        vecs.push_back('{1, 8'h3C, 0, 0, 1, 0, 0, 8'h3C, 0});
        for (int i = 0; i < 4; i++) vecs.push_back('{1, 8'h3C, 0, 0, 1, 0, 0, 8'h3C, 0});
        vecs.push_back('{0, 8'h00, 0, 0, 1, 0, 0, 8'h3C, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0});
        vecs.push_back('{1, 8'h42, 1, 0, 1, 0, 0, 8'h42, 0});
        vecs.push_back('{0, 8'h00, 0, 0, 1, 0, 0, 8'h42, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0});
        foreach (vecs[i]) begin
            step(vecs[i].tick, vecs[i].data, vecs[i].rd, vecs[i].clr);
            check("vec_count", 32'(bus.count), 32'(vecs[i].e_count));
            check("vec_empty", 32'(bus.empty), 32'(vecs[i].e_empty));
            check("vec_full", 32'(bus.full), 32'(vecs[i].e_full));
            check("vec_rdata", 32'(bus.r_data), 32'(vecs[i].e_rdata));
            check("vec_ovr", 32'(bus.overrun), 32'(vecs[i].e_ovr));
        end

        // fill, overflow drop, drain in order
        for (int i = 0; i < 16; i++) wr(8'(i));
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_count", 32'(bus.count), 32'd16);
        wr(8'hFF);
        check("drop_ovr", 32'(bus.overrun), 32'd1);
        check("drop_head", 32'(bus.r_data), 32'h00);
        for (int i = 0; i < 16; i++) begin
            check("drain_seq", 32'(bus.r_data), 32'(i));
            pop_one();
        end
        check("drain_empty", 32'(bus.empty), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_ovr", 32'(bus.overrun), 32'd0);

        // simultaneous write and read while full, across the pointer wrap
        for (int i = 0; i < 16; i++) wr(8'(i));
        step(1'b1, 8'h77, 1'b1, 1'b0);
        check("sim_count", 32'(bus.count), 32'd16);
        check("sim_ovr", 32'(bus.overrun), 32'd0);
        check("sim_head", 32'(bus.r_data), 32'h01);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) pop_one();
        check("wrap_last", 32'(bus.r_data), 32'h77);
        pop_one();
        check("wrap_empty", 32'(bus.empty), 32'd1);

        // drop coinciding with clear: set wins
        for (int i = 0; i < 16; i++) wr(8'(i + 8'h80));
        step(1'b1, 8'h11, 1'b0, 1'b1);
        check("set_wins", 32'(bus.overrun), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_after", 32'(bus.overrun), 32'd0);
        for (int i = 0; i < 16; i++) pop_one();

        // reset mid-stream with rx_done_tick held high
        wr(8'h01);
        wr(8'h02);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_count", 32'(bus.count), 32'd0);
        repeat (2) @(posedge clk);
        #1 compare_model();
        @(negedge clk) reset = 1'b1;
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        check("rst_tick_write", 32'(bus.count), 32'd1);
        check("rst_tick_data", 32'(bus.r_data), 32'h5A);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        check("rst_tick_once", 32'(bus.count), 32'd1);

        // random traffic
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 99) < 45), 8'($urandom),
                 1'($urandom_range(0, 99) < (i < 300 ? 20 : 45)),
                 1'($urandom_range(0, 99) < 5));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer that sits directly downstream of the UART receiver.
- Captures each received word, qualified by the receiver's done tick, into a circular FIFO.
- Presents words to the host with first-word-fall-through semantics.
- Flags overrun when the receiver delivers a word while the buffer is full.

Parameters:
DATA_WIDTH, 8, width of each received word; must match the receiver's DATA_WIDTH.
ADDR_WIDTH, 4, log2 of FIFO depth; depth = 2**ADDR_WIDTH (16 by default).

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset.
rx_data  input  DATA_WIDTH  received word from the receiver; valid when rx_done_tick is high.
rx_done_tick  input  1  receiver completion flag; may stay high for more than one cycle.
rd  input  1  host read strobe; pops the head entry at the next rising edge.
r_data  output  DATA_WIDTH  head-of-FIFO word (first-word-fall-through).
empty  output  1  FIFO holds no entries.
full  output  1  FIFO holds 2**ADDR_WIDTH entries.
count  output  ADDR_WIDTH+1  number of stored entries, 0 to 2**ADDR_WIDTH.
overrun  output  1  sticky flag: a word was dropped because the FIFO was full.
clr_overrun  input  1  synchronous clear for overrun.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overrun=0.
  - tick_q=0 (edge-detect register).
  - Storage array is not reset.
- Write qualification:
  - wr_pulse = rx_done_tick & ~tick_q, where tick_q registers rx_done_tick every cycle.
  - Only the 0->1 transition writes; rx_done_tick held high for N cycles produces exactly one write.
  - On the edge where wr_pulse=1, rx_data is sampled into mem[wr_ptr].
- Read:
  - rd=1 with empty=0 advances rd_ptr at the rising edge.
  - rd=1 with empty=1 is ignored: no pointer or count change, no error flag.
- r_data:
  - r_data = mem[rd_ptr] combinationally when empty=0.
  - r_data = 0 when empty=1.
  - A written word appears on r_data, and empty falls, immediately after the write edge (one-cycle latency from the wr_pulse edge).
- Pointers: ADDR_WIDTH bits each, wrap modulo 2**ADDR_WIDTH with no special casing.
- count update per edge:
  - +1 on accepted write only.
  - -1 on accepted read only.
  - Unchanged when both occur or neither occurs.
- Flags: empty = (count==0); full = (count==2**ADDR_WIDTH). Both are registered or derived from the registered count, so they are glitch-free.
- Simultaneous events:
  - wr_pulse & rd when empty: write accepted, read ignored; count becomes 1.
  - wr_pulse & rd when full: read pops the head and the write is accepted into the freed slot; count stays full; overrun not set.
  - wr_pulse when full without rd: word dropped, pointers unchanged, overrun<=1.
- overrun:
  - Sticky until clr_overrun=1.
  - If a drop and clr_overrun coincide, set wins (overrun stays 1).
- Reset mid-operation:
  - All stored data is discarded logically (empty=1 immediately, asynchronously).
  - A pending rx_done_tick high at reset release counts as one write, because tick_q=0.
- No state machine beyond the pointer/count datapath. The edge detector is the only control register besides overrun.

Test Plan:
1. Reset, then rx_done_tick pulsed 1 cycle with rx_data=0xA5 -> next cycle empty=0, count=1, r_data=0xA5; rd=1 one cycle -> empty=1, count=0, r_data=0.
2. rx_done_tick held high 5 cycles with rx_data=0x3C -> exactly one entry stored, count=1.
3. Write 16 words 0x00..0x0F (default depth) -> full=1, count=16; 17th write 0xFF -> dropped, overrun=1; read 16 words -> sequence 0x00..0x0F, then empty=1.
4. Fill to full, then assert wr_pulse (0x77) and rd together -> head 0x00 popped, count stays 16, overrun stays 0; read all 16 -> last word 0x77 (pointer wrap verified).
5. Empty FIFO, wr_pulse (0x42) and rd together -> count=1, r_data=0x42. rd on empty -> no change. Drop coinciding with clr_overrun=1 -> overrun=1.
6. Load 3 words, assert reset=0 mid-stream with rx_done_tick=1, release -> empty=1 during reset; after release one write occurs, so count=1.
